// File: rtl/pipe_ctrl.sv
// Purpose: pipeline sequencer - merges stage stall requests, sequences exception/ERET flushes, watches for runaway stalls.
// Latency: stall is combinational from the requests; flush/new_pc appear the cycle after exc_valid is sampled.
// Backpressure: stall[5:0] holds PC and the inter-stage registers; optional stall-cycle counter under PIPE_CTRL_STATS_EN.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
    parameter int unsigned REFILL_CYC = 2,
    parameter logic [15:0] STALL_MAX  = 16'd1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        exc_valid,
    input  logic        exc_eret,
    input  logic [31:0] cp0_epc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_REFILL = 2'd2
    } state_t;

    localparam logic [3:0] REFILL_LD = 4'(REFILL_CYC);

    state_t      state_q, state_d;
    logic [31:0] target_q, target_d;
    logic [3:0]  refill_q, refill_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic [15:0] run_q, run_d;
    logic        timeout_q, timeout_d;
    logic [5:0]  stall_req_vec;

    // Priority-merge the stage requests; the vector is suppressed in reset and during the flush cycle.
    always_comb begin
        stall_req_vec = 6'b000000;
        if (stallreq_mem) begin
            stall_req_vec = 6'b011111;
        end else if (stallreq_ex) begin
            stall_req_vec = 6'b001111;
        end else if (stallreq_id) begin
            stall_req_vec = 6'b000111;
        end else if (stallreq_if) begin
            stall_req_vec = 6'b000011;
        end
        stall = (rst || (state_q == ST_FLUSH)) ? 6'b000000 : stall_req_vec;
    end

    // Flush FSM next state: accept exceptions only in IDLE, then one flush cycle and a refill blackout.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        refill_d = refill_q;
        case (state_q)
            ST_IDLE: begin
                if (exc_valid) begin
                    target_d = exc_eret ? cp0_epc : EXC_VECTOR;
                    state_d  = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d  = ST_REFILL;
                refill_d = REFILL_LD;
            end
            ST_REFILL: begin
                // Blackout lasts REFILL_CYC cycles; leave when the last one is consumed.
                if (refill_q <= 4'd1) begin
                    state_d  = ST_IDLE;
                    refill_d = 4'd0;
                end else begin
                    refill_d = refill_q - 4'd1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                refill_d = 4'd0;
            end
        endcase
        flush_d  = (state_d == ST_FLUSH);
        new_pc_d = flush_d ? target_d : 32'h0;
    end

    // FSM state and its registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            target_q <= 32'h0;
            refill_q <= 4'd0;
            flush_q  <= 1'b0;
            new_pc_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            refill_q <= refill_d;
            flush_q  <= flush_d;
            new_pc_q <= new_pc_d;
        end
    end

    assign flush  = flush_q;
    assign new_pc = new_pc_q;

    // Consecutive PC-stall run length, saturating at STALL_MAX; reaching it latches the sticky timeout.
    always_comb begin
        run_d = 16'd0;
        if (stall[0] && (state_q != ST_FLUSH)) begin
            run_d = (run_q >= STALL_MAX) ? STALL_MAX : run_q + 16'd1;
        end
        timeout_d = timeout_q | (run_d == STALL_MAX);
    end

    // Run counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q     <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            run_q     <= run_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall_timeout = timeout_q;

`ifdef PIPE_CTRL_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    // Free-running count of PC-stall cycles, wrapping at 2^32.
    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'b0, stall[0]};
    end

    // Stall-cycle counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= 32'h0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Purpose: scoreboard bench for pipe_ctrl - directed scenarios followed by randomized traffic.
// Latency: expected per-cycle outputs are queued by the driver and popped by a negedge monitor.
// Backpressure: none; the monitor consumes one expectation per cycle.
module tb_pipe_ctrl;

    localparam logic [31:0] EXC_VEC_TB   = 32'h0000_0040;
    localparam int          REFILL_TB    = 2;
    localparam int          STALL_MAX_TB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_if = 1'b0;
    logic        stallreq_id = 1'b0;
    logic        stallreq_ex = 1'b0;
    logic        stallreq_mem = 1'b0;
    logic        exc_valid = 1'b0;
    logic        exc_eret = 1'b0;
    logic [31:0] cp0_epc = 32'h0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic [31:0] stall_cycles;

    pipe_ctrl #(
        .EXC_VECTOR (EXC_VEC_TB),
        .REFILL_CYC (REFILL_TB),
        .STALL_MAX  (16'(STALL_MAX_TB))
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_if   (stallreq_if),
        .stallreq_id   (stallreq_id),
        .stallreq_ex   (stallreq_ex),
        .stallreq_mem  (stallreq_mem),
        .exc_valid     (exc_valid),
        .exc_eret      (exc_eret),
        .cp0_epc       (cp0_epc),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .stall_timeout (stall_timeout),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
        logic        to;
        logic [31:0] cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model: a pending-flush flag, a blackout countdown, a run length and totals.
    bit          m_flush_now = 1'b0;
    int          m_ignore    = 0;
    logic [31:0] m_target    = 32'h0;
    int          m_run       = 0;
    bit          m_to        = 1'b0;
    logic [31:0] m_cyc       = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: drive inputs, queue the expected outputs, advance the model past the edge.
    task automatic step(input bit r, input bit fi, input bit fd, input bit fe, input bit fm,
                        input bit ev, input bit er, input logic [31:0] epc);
        exp_t       e;
        int         lvl;
        logic [5:0] vec;
        @(posedge clk);
        #1;
        rst = r; stallreq_if = fi; stallreq_id = fd; stallreq_ex = fe; stallreq_mem = fm;
        exc_valid = ev; exc_eret = er; cp0_epc = epc;

        // Deepest requesting stage sets how many low stall bits are held: PC plus that many stages.
        lvl = fm ? 4 : fe ? 3 : fd ? 2 : fi ? 1 : 0;
        vec = (lvl == 0) ? 6'd0 : 6'((1 << (lvl + 1)) - 1);
        e.stall  = (r || m_flush_now) ? 6'd0 : vec;
        e.flush  = m_flush_now;
        e.new_pc = m_flush_now ? m_target : 32'h0;
        e.to     = m_to;
`ifdef PIPE_CTRL_STATS_EN
        e.cyc    = m_cyc;
`else
        e.cyc    = 32'h0;
`endif
        exp_q.push_back(e);

        if (r) begin
            m_flush_now = 1'b0; m_ignore = 0; m_target = 32'h0;
            m_run = 0; m_to = 1'b0; m_cyc = 32'h0;
        end else begin
            if (e.stall[0]) begin
                m_run = (m_run + 1 > STALL_MAX_TB) ? STALL_MAX_TB : m_run + 1;
                m_cyc = m_cyc + 32'd1;
            end else begin
                m_run = 0;
            end
            if (m_run == STALL_MAX_TB) m_to = 1'b1;
            if (m_flush_now) begin
                m_flush_now = 1'b0;
                m_ignore    = REFILL_TB;
            end else if (m_ignore > 0) begin
                m_ignore--;
            end else if (ev) begin
                m_flush_now = 1'b1;
                m_target    = er ? epc : EXC_VEC_TB;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    // Monitor: compare every queued expectation against the DUT mid-cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall",         {26'b0, stall},          {26'b0, e.stall});
                chk("flush",         {31'b0, flush},          {31'b0, e.flush});
                chk("new_pc",        new_pc,                  e.new_pc);
                chk("stall_timeout", {31'b0, stall_timeout},  {31'b0, e.to});
                chk("stall_cycles",  stall_cycles,            e.cyc);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int wait_cyc;
        // Reset with every request and an exception asserted.
        step(1, 1, 1, 1, 1, 1, 0, 32'h0);
        step(1, 1, 1, 1, 1, 1, 1, 32'hDEAD_BEEF);
        idle(2);

        // Stall priority merging.
        step(0, 0, 1, 0, 1, 0, 0, 32'h0);
        step(0, 0, 1, 0, 0, 0, 0, 32'h0);
        step(0, 1, 0, 0, 0, 0, 0, 32'h0);
        step(0, 1, 1, 1, 0, 0, 0, 32'h0);
        idle(2);

        // Exception with blackout: pulses during refill are dropped, a later one flushes.
        step(0, 0, 0, 0, 0, 1, 0, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 1, 1, 32'h1111_0000);
        step(0, 0, 0, 0, 0, 1, 1, 32'h2222_0000);
        step(0, 0, 0, 0, 0, 1, 0, 32'h0);
        idle(4);

        // ERET returns to EPC; exception together with a stall request.
        step(0, 0, 0, 0, 0, 1, 1, 32'h8000_1234);
        idle(4);
        step(0, 0, 0, 1, 0, 1, 1, 32'h0000_ABC0);
        step(0, 0, 0, 1, 0, 0, 0, 32'h0);
        idle(4);

        // Reset during flush discards the target.
        step(0, 0, 0, 0, 0, 1, 0, 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, 32'h0);
        idle(3);

        // Timeout: a 3-cycle stall stays below threshold, a 4-cycle stall sets the sticky flag.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 0, 32'h0);
        idle(2);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, 0, 32'h0);
        idle(3);

        // Stall-cycle accounting: 5 ex cycles, a gap, 3 mem cycles.
        step(1, 0, 0, 0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, 0, 32'h0);
        idle(2);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0, 32'h0);
        idle(2);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                 $urandom());
        end
        idle(2);

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        @(posedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
